// File: rtl/ysyx_23060221_ifu_pkg.sv
// Shared types and constants for the ysyx_23060221 instruction fetch unit.
// RESET_PC is also used by PC generation so both ends agree on the boot address.
package ysyx_23060221_ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_BUSERR   = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam logic [31:0] RESET_PC = 32'h30000000;

endpackage

// File: rtl/ysyx_23060221_ifu_watchdog.sv
// Bus watchdog for the fetch unit: counts cycles spent waiting on the read channel.
// Only built when IFU_TIMEOUT_EN is defined.
`ifdef IFU_TIMEOUT_EN
module ysyx_23060221_ifu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count;

  // Counter parks at the expiry value so a stuck caller never wraps it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/ysyx_23060221_ifu.sv
// Instruction fetch unit: takes a PC from WBU, performs one read on the bus and hands
// the word to IDU. Define IFU_TIMEOUT_EN to add a bus watchdog (fault cause 11).
module ysyx_23060221_ifu #(
   parameter logic [31:0] NOP_INST = ysyx_23060221_ifu_pkg::NOP_INST,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WBU_valid,
   output logic        IFU_ready,
   input  logic [31:0] pc,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        IFU_valid,
   input  logic        IDU_ready,
   output logic        fetch_fault,
   output logic [1:0]  fault_cause
);

   import ysyx_23060221_ifu_pkg::*;

   ifu_state_t state;
   logic       timeout;

`ifdef IFU_TIMEOUT_EN
   ysyx_23060221_ifu_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == IDLE),
      .count_en(state == AR || state == R),
      .expired (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   // Main fetch FSM; a completing handshake is checked before the watchdog so it always wins a tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         IFU_ready   <= 1'b1;
         arvalid     <= 1'b0;
         rready      <= 1'b0;
         IFU_valid   <= 1'b0;
         fetch_fault <= 1'b0;
         fault_cause <= FC_NONE;
         araddr      <= '0;
         inst        <= NOP_INST;
         inst_pc     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (WBU_valid && IFU_ready) begin
                  inst_pc   <= pc;
                  IFU_ready <= 1'b0;
                  if (pc[1:0] != 2'b00) begin
                     inst        <= NOP_INST;
                     fetch_fault <= 1'b1;
                     fault_cause <= FC_MISALIGN;
                     IFU_valid   <= 1'b1;
                     state       <= HOLD;
                  end else begin
                     araddr  <= pc;
                     arvalid <= 1'b1;
                     state   <= AR;
                  end
               end
            end
            AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= R;
               end else if (timeout) begin
                  arvalid     <= 1'b0;
                  inst        <= NOP_INST;
                  fetch_fault <= 1'b1;
                  fault_cause <= FC_TIMEOUT;
                  IFU_valid   <= 1'b1;
                  state       <= HOLD;
               end
            end
            R: begin
               if (rvalid) begin
                  rready    <= 1'b0;
                  IFU_valid <= 1'b1;
                  state     <= HOLD;
                  if (rresp == 2'b00) begin
                     inst <= rdata;
                  end else begin
                     inst        <= NOP_INST;
                     fetch_fault <= 1'b1;
                     fault_cause <= FC_BUSERR;
                  end
               end else if (timeout) begin
                  rready      <= 1'b0;
                  inst        <= NOP_INST;
                  fetch_fault <= 1'b1;
                  fault_cause <= FC_TIMEOUT;
                  IFU_valid   <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (IFU_valid && IDU_ready) begin
                  IFU_valid   <= 1'b0;
                  fetch_fault <= 1'b0;
                  fault_cause <= FC_NONE;
                  IFU_ready   <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ysyx_23060221_ifu.md
Name: ysyx_23060221_ifu

Overview:
Instruction fetch unit. Sits between the write-back stage and decode, and is the consumer end of the WBU->IFU valid/ready handshake.
- Accepts the next PC from WBU.
- Issues one read on a single-outstanding AXI-lite-style read channel.
- Returns the instruction word, its PC and a fault indication to IDU over a valid/ready handshake.
- Strictly one instruction in flight, matching the multi-cycle handshaked core.

Parameters:
TIMEOUT_CYCLES, 256, max cycles spent in AR+R states before a bus-timeout fault (used only with IFU_TIMEOUT_EN).
NOP_INST, 32'h00000013, instruction word presented on any fault.

Ports:
clk  in  1  core clock.
rst  in  1  synchronous active-high reset.
WBU_valid  in  1  WBU offers next PC.
IFU_ready  out  1  IFU can accept a PC.
pc  in  32  next PC; sampled on WBU handshake.
araddr  out  32  read address.
arvalid  out  1  address valid.
arready  in  1  address accepted.
rdata  in  32  read data.
rresp  in  2  read response; 0 = OKAY, nonzero = error.
rvalid  in  1  read data valid.
rready  out  1  IFU accepts read data.
inst  out  32  fetched instruction.
inst_pc  out  32  PC of inst.
IFU_valid  out  1  inst/inst_pc/fault valid to IDU.
IDU_ready  in  1  IDU accepts.
fetch_fault  out  1  fault on this fetch.
fault_cause  out  2  01 misaligned, 10 bus error, 11 timeout, 00 none.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, IFU_ready=1, arvalid=0, rready=0, IFU_valid=0, fetch_fault=0, fault_cause=0, araddr=0, inst=NOP_INST, inst_pc=0.
- Reset mid-operation: abandons any transaction immediately; arvalid and rready are 0 from the next edge. The memory side shares rst, so no stale response survives.
- FSM states: IDLE, AR, R, HOLD.
- IDLE: IFU_ready=1. On WBU_valid & IFU_ready:
  - inst_pc<=pc, IFU_ready<=0.
  - If pc[1:0]!=0: no bus access. inst<=NOP_INST, fetch_fault<=1, fault_cause<=01, IFU_valid<=1, go to HOLD.
  - Else: araddr<=pc, arvalid<=1, go to AR.
- AR: arvalid and araddr are held stable until arready. On arready: arvalid<=0, rready<=1, go to R.
- R: on rvalid:
  - rready<=0, IFU_valid<=1, go to HOLD.
  - If rresp==0: inst<=rdata.
  - Else: inst<=NOP_INST, fetch_fault<=1, fault_cause<=10.
  - An rvalid seen in any state other than R is ignored.
- HOLD: inst, inst_pc, fetch_fault and fault_cause are stable while IFU_valid=1. On IFU_valid & IDU_ready: IFU_valid<=0, fetch_fault<=0, fault_cause<=0, IFU_ready<=1, go to IDLE.
- Latency: minimum 3 cycles from WBU handshake edge to IFU_valid=1 (arvalid at +1, rready at +2, IFU_valid at +3). Each cycle of arready/rvalid delay adds one cycle.
- Throughput: at most one fetch per 4 cycles. IFU_ready and IFU_valid are never both 1.
- Simultaneous events: arready and rvalid in the same AR cycle. Only arready is consumed; rvalid is taken in R. The slave must hold rvalid until rready.

Optional Feature:
IFU_TIMEOUT_EN
- Defined: a cycle counter clears on entry to AR and increments each cycle in AR or R. When it reaches TIMEOUT_CYCLES-1 with no completing handshake:
  - arvalid<=0, rready<=0.
  - inst<=NOP_INST, fetch_fault<=1, fault_cause<=11, IFU_valid<=1, go to HOLD.
  - A handshake in that same cycle wins over the timeout.
- Undefined: no counter. The unit waits indefinitely; fault_cause 11 never occurs.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE/AR/R/HOLD).
  - Fault cause constants: FC_NONE=00, FC_MISALIGN=01, FC_BUSERR=10, FC_TIMEOUT=11.
  - NOP_INST constant.
  - Reset PC 32'h30000000, shared with PC generation.
- One sub-module, ysyx_23060221_ifu_watchdog (counter plus expiry flag), instantiated only under IFU_TIMEOUT_EN.

Test Plan:
- Zero-wait fetch: rst, then pc=0x30000000 handshake; arready=1 and rvalid=1 with rdata=0x00100093 when offered -> araddr=0x30000000 at +1; IFU_valid at +3 with inst=0x00100093, inst_pc=0x30000000, fetch_fault=0.
- Backpressure: arready delayed 3 cycles, rvalid delayed 2, IDU_ready low 4 cycles -> araddr stable throughout, IFU_valid=1 at +8, outputs stable while held, IFU_ready=1 the cycle after IDU handshake.
- Misaligned: pc=0x30000002 -> no arvalid ever; IFU_valid at +1 with inst=0x00000013, fault_cause=01.
- Bus error: rresp=2'b10, rdata=0xDEADBEEF -> inst=0x00000013, fetch_fault=1, fault_cause=10; fault clears after IDU handshake.
- Reset mid-R: assert rst while rready=1 -> next cycle rready=0, IFU_ready=1, IFU_valid=0; a following fetch of pc=0x30000004 completes normally.
- Timeout (IFU_TIMEOUT_EN, TIMEOUT_CYCLES=8): arready never asserted -> arvalid drops and IFU_valid=1 with fault_cause=11 exactly 8 cycles after entering AR.
